sram_cycle_sequencer: RTL

- Clocked sequencer that owns the shared external SRAM (main RAM plus MMU tag/map RAM) and generates its chip-enable and write-enable strobes.
- For every C64 DRAM cycle it runs a tag-lookup phase, latches the MMU page, then opens the data access to main RAM or to the map area.
- Between C64 cycles it grants the SRAM to a secondary DMA/initialiser port.
- It sits between the bus decode (RAS/CAS, register/map hits) and the SRAM pin drivers, replacing free-running counter timing.

---
 rtl/ultimem_pkg.sv | 35 +++
 rtl/sram_cycle_sequencer_phase_counter.sv | 47 ++++
 rtl/sram_cycle_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ultimem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ultimem_pkg
// Description : Shared state encoding and default phase lengths for the
//               SRAM cycle sequencer and the top-level address muxing.
// Revision    : 1.0 - initial release
// ============================================================================
package ultimem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TAG      = 3'd1,
        ST_DATA_RAM = 3'd2,
        ST_DATA_MAP = 3'd3,
        ST_REG      = 3'd4,
        ST_DMA      = 3'd5
    } seq_state_t;

    localparam int c_tag_cycles = 2;
    localparam int c_dma_cycles = 3;
    localparam int c_ctr_w      = 4;

    // Last counter value of the timed phase owned by a state; untimed states use 0.
    function automatic int phase_limit(input seq_state_t s,
                                       input int tag_cycles,
                                       input int dma_cycles);
        case (s)
            ST_TAG:  return tag_cycles - 1;
            ST_DMA:  return dma_cycles - 1;
            default: return 0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_cycle_sequencer_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : phase_counter
// Description : Clearable saturating phase counter with a terminal flag
//               compared against a runtime limit.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_count_next,
    output logic             o_terminal
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;

    // Holds at all-ones instead of wrapping back into an early phase.
    always_comb begin
        w_count_next = r_count;
        if (i_clear) begin
            w_count_next = '0;
        end else if (i_enable && (r_count != {WIDTH{1'b1}})) begin
            w_count_next = r_count + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count      = r_count;
    assign o_count_next = w_count_next;
    assign o_terminal   = (r_count >= i_limit);

endmodule
`default_nettype wire

// File: rtl/sram_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sram_cycle_sequencer
// Description : Owns the shared SRAM: tag lookup and data phase per C64
//               cycle, DMA accesses in between. All strobes are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_cycle_sequencer
    import ultimem_pkg::*;
#(
    parameter int TAG_CYCLES = c_tag_cycles,
    parameter int DMA_CYCLES = c_dma_cycles,
    parameter int CTR_W      = c_ctr_w
) (
    input  logic clock,
    input  logic reset,
    input  logic bus_active,
    input  logic bus_we,
    input  logic reg_hit,
    input  logic map_hit,
    input  logic dma_req,
    input  logic dma_we,
    output logic ce_ram,
    output logic ce_tag,
    output logic we_ram,
    output logic tag_latch,
    output logic dma_sel,
    output logic dma_ack,
    output logic busy
);

    localparam logic [CTR_W-1:0] c_tag_last = CTR_W'(TAG_CYCLES - 1);
    localparam logic [CTR_W-1:0] c_dma_last = CTR_W'(DMA_CYCLES - 1);

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic             w_clear;
    logic             w_enable;
    logic [CTR_W-1:0] w_limit;
    logic [CTR_W-1:0] w_count;
    logic [CTR_W-1:0] w_count_next;
    logic             w_terminal;

    logic r_ce_ram, r_ce_tag, r_we_ram, r_tag_latch, r_dma_sel, r_dma_ack, r_busy;
    logic w_ce_ram, w_ce_tag, w_we_ram, w_tag_latch, w_dma_sel, w_dma_ack, w_busy;

    assign w_limit = CTR_W'(phase_limit(r_state, TAG_CYCLES, DMA_CYCLES));

    phase_counter #(
        .WIDTH(CTR_W)
    ) u_phase_counter (
        .clock        (clock),
        .reset        (reset),
        .i_clear      (w_clear),
        .i_enable     (w_enable),
        .i_limit      (w_limit),
        .o_count      (w_count),
        .o_count_next (w_count_next),
        .o_terminal   (w_terminal)
    );

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b1;
        w_enable     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // The C64 cycle cannot be stretched, so it always wins over DMA.
                if (bus_active) begin
                    w_state_next = ST_TAG;
                end else if (dma_req) begin
                    w_state_next = ST_DMA;
                end
            end
            ST_TAG: begin
                if (!bus_active) begin
                    w_state_next = ST_IDLE;
                end else if (w_terminal) begin
                    if (map_hit) begin
                        w_state_next = ST_DATA_MAP;
                    end else if (reg_hit) begin
                        w_state_next = ST_REG;
                    end else begin
                        w_state_next = ST_DATA_RAM;
                    end
                end else begin
                    w_clear  = 1'b0;
                    w_enable = 1'b1;
                end
            end
            ST_DATA_RAM, ST_DATA_MAP, ST_REG: begin
                if (!bus_active) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DMA: begin
                // Preempted access is abandoned without ack; the requester retries.
                if (bus_active) begin
                    w_state_next = ST_TAG;
                end else if (w_terminal) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_clear  = 1'b0;
                    w_enable = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_ce_ram    = 1'b0;
        w_ce_tag    = 1'b0;
        w_we_ram    = 1'b0;
        w_tag_latch = 1'b0;
        w_dma_sel   = 1'b0;
        w_dma_ack   = 1'b0;
        w_busy      = (w_state_next != ST_IDLE);
        case (w_state_next)
            ST_TAG: begin
                w_ce_tag    = 1'b1;
                w_tag_latch = (w_count_next == c_tag_last);
            end
            ST_DATA_RAM: begin
                w_ce_ram = 1'b1;
                w_we_ram = bus_we;
            end
            ST_DATA_MAP: begin
                w_ce_tag = 1'b1;
                w_we_ram = bus_we;
            end
            ST_DMA: begin
                w_dma_sel = 1'b1;
                w_ce_ram  = 1'b1;
                w_we_ram  = dma_we;
                w_dma_ack = (w_count_next == c_dma_last);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ce_ram    <= 1'b0;
            r_ce_tag    <= 1'b0;
            r_we_ram    <= 1'b0;
            r_tag_latch <= 1'b0;
            r_dma_sel   <= 1'b0;
            r_dma_ack   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ce_ram    <= w_ce_ram;
            r_ce_tag    <= w_ce_tag;
            r_we_ram    <= w_we_ram;
            r_tag_latch <= w_tag_latch;
            r_dma_sel   <= w_dma_sel;
            r_dma_ack   <= w_dma_ack;
            r_busy      <= w_busy;
        end
    end

    assign ce_ram    = r_ce_ram;
    assign ce_tag    = r_ce_tag;
    assign we_ram    = r_we_ram;
    assign tag_latch = r_tag_latch;
    assign dma_sel   = r_dma_sel;
    assign dma_ack   = r_dma_ack;
    assign busy      = r_busy;

    always_comb begin
        assert (!(r_ce_ram && r_ce_tag));
        assert (!r_we_ram || r_ce_ram || r_ce_tag);
        assert (!(r_we_ram && (r_state == ST_TAG)));
        assert (!r_dma_sel || (r_state == ST_DMA));
        assert (w_count <= w_limit);
    end

endmodule
`default_nettype wire
